// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbitrating multiplexer.
// Picks one requesting channel per cycle (round-robin or fixed priority)
// and forwards its word through a one-entry output register.
module rr_arb_mux #(
   parameter int WIDTH = 32,
   parameter int N     = 8,
   parameter int MODE  = 0,
   parameter int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_src
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [SELW-1:0]  r_src;
   logic [SELW-1:0]  r_ptr;

   logic             w_found;
   logic [SELW-1:0]  w_gnt;
   logic             w_can_accept;
   logic [N-1:0]     w_ready;
   logic             w_xfer_in;
   logic             w_xfer_out;

   // The register can take a new word when empty or draining this cycle.
   assign w_can_accept = !r_valid | out_ready;

   // Grant search: round-robin starts just after the last accepted channel,
   // fixed priority starts at channel 0. First valid channel found wins.
   always_comb begin
      int unsigned idx;
      w_found = 1'b0;
      w_gnt   = '0;
      for (int k = 0; k < N; k++) begin
         if (MODE == 0) begin
            idx = int'(r_ptr) + 1 + k;
            if (idx >= N) idx = idx - N;
         end else begin
            idx = k;
         end
         if (!w_found && in_valid[idx]) begin
            w_found = 1'b1;
            w_gnt   = SELW'(idx);
         end
      end
   end

   // One-hot ready toward the granted channel only; silenced during reset.
   always_comb begin
      w_ready = '0;
      if (w_found && w_can_accept && !rst)
         w_ready = N'(1) << w_gnt;
   end

   assign in_ready   = w_ready;
   assign w_xfer_in  = |(in_valid & w_ready);
   assign w_xfer_out = r_valid & out_ready;

   // Output register and round-robin pointer. The pointer only moves on an
   // accepted word so a stalled offer cannot skip a channel's turn.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_src   <= '0;
         r_ptr   <= SELW'(N - 1);
      end else if (w_xfer_in) begin
         r_valid <= 1'b1;
         r_data  <= in_data[w_gnt*WIDTH +: WIDTH];
         r_src   <= w_gnt;
         if (MODE == 0) r_ptr <= w_gnt;
      end else if (w_xfer_out) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_src   = r_src;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: one round-robin and one fixed-priority
// instance share the same stimulus; each step checks the relevant instance.
module tb_rr_arb_mux;

   localparam int W = 32;
   localparam int N = 8;
   localparam int S = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic           out_ready;

   logic [N-1:0]   rr_in_ready, fp_in_ready;
   logic           rr_out_valid, fp_out_valid;
   logic [W-1:0]   rr_out_data, fp_out_data;
   logic [S-1:0]   rr_out_src, fp_out_src;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rr_arb_mux #(.WIDTH(W), .N(N), .MODE(0)) u_rr (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_ready(out_ready),
      .out_data(rr_out_data), .out_src(rr_out_src));

   rr_arb_mux #(.WIDTH(W), .N(N), .MODE(1)) u_fp (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_ready(out_ready),
      .out_data(fp_out_data), .out_src(fp_out_src));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and land 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic data_idx();
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i);
   endtask

   initial begin
      rst = 1'b1; in_valid = '0; out_ready = 1'b0; data_idx();

      // --- 1: reset, then single request on ch2 ---
      in_valid = 8'hFF; out_ready = 1'b1;
      tick();
      chk("rst_in_ready", 32'(rr_in_ready), 32'h0);
      tick();
      rst = 1'b0; in_valid = '0;
      #1;
      chk("rst_out_valid", 32'(rr_out_valid), 32'h0);
      chk("rst_out_data", rr_out_data, 32'h0);
      chk("rst_out_src", 32'(rr_out_src), 32'h0);
      in_valid = 8'h04; in_data[2*W +: W] = 32'hDEAD_BEEF;
      #1;
      chk("t1_in_ready", 32'(rr_in_ready), 32'h04);
      tick();
      in_valid = '0;
      chk("t1_valid", 32'(rr_out_valid), 32'h1);
      chk("t1_data", rr_out_data, 32'hDEAD_BEEF);
      chk("t1_src", 32'(rr_out_src), 32'h2);
      tick();
      chk("t1_drain_valid", 32'(rr_out_valid), 32'h0);
      chk("t1_drain_hold", rr_out_data, 32'hDEAD_BEEF);

      // --- 2: round-robin rotation from fresh reset ---
      rst = 1'b1; tick(); rst = 1'b0;
      data_idx(); in_valid = 8'hFF; out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("t2_valid_%0d", k), 32'(rr_out_valid), 32'h1);
         chk($sformatf("t2_src_%0d", k), 32'(rr_out_src), 32'(k % 8));
         chk($sformatf("t2_data_%0d", k), rr_out_data, 32'(k % 8));
         chk($sformatf("t2_fp_src_%0d", k), 32'(fp_out_src), 32'h0);
      end

      // --- 3: backpressure hold with ch5 word registered (ptr=1 here) ---
      in_data[5*W +: W] = 32'h5555_0005; in_valid = 8'h20;
      tick();
      chk("t3_load_src", 32'(rr_out_src), 32'h5);
      out_ready = 1'b0; in_valid = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("t3_stall_ready_%0d", k), 32'(rr_in_ready), 32'h0);
         tick();
         chk($sformatf("t3_hold_valid_%0d", k), 32'(rr_out_valid), 32'h1);
         chk($sformatf("t3_hold_src_%0d", k), 32'(rr_out_src), 32'h5);
         chk($sformatf("t3_hold_data_%0d", k), rr_out_data, 32'h5555_0005);
      end
      out_ready = 1'b1;
      #1;
      chk("t3_resume_ready", 32'(rr_in_ready), 32'h40);
      tick();
      chk("t3_resume_src", 32'(rr_out_src), 32'h6);
      chk("t3_resume_data", rr_out_data, 32'h6);

      // --- 4: fixed priority ---
      in_valid = 8'b1010_0100;
      #1;
      chk("t4_fp_ready", 32'(fp_in_ready), 32'h04);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("t4_src2_%0d", k), 32'(fp_out_src), 32'h2);
      end
      in_valid = 8'b1010_0000;
      tick();
      chk("t4_src5", 32'(fp_out_src), 32'h5);
      tick();
      chk("t4_src5b", 32'(fp_out_src), 32'h5);
      in_valid = 8'b1000_0000;
      tick();
      chk("t4_src7", 32'(fp_out_src), 32'h7);
      chk("t4_data7", fp_out_data, 32'h7);

      // --- 5: wrap-around, last grant ch7 ---
      tick();
      chk("t5_grant7", 32'(rr_out_src), 32'h7);
      in_valid = 8'h81;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("t5_wrap_%0d", k), 32'(rr_out_src), (k % 2 == 0) ? 32'h0 : 32'h7);
      end

      // --- 6: reset mid-operation ---
      in_valid = 8'h08; in_data[3*W +: W] = 32'h3333_0003;
      tick();
      chk("t6_load_src", 32'(rr_out_src), 32'h3);
      out_ready = 1'b0; in_valid = '0;
      tick();
      chk("t6_stall_valid", 32'(rr_out_valid), 32'h1);
      chk("t6_stall_data", rr_out_data, 32'h3333_0003);
      rst = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
      #1;
      chk("t6_rst_ready", 32'(rr_in_ready), 32'h0);
      tick();
      rst = 1'b0; in_valid = 8'h88;
      chk("t6_rst_valid", 32'(rr_out_valid), 32'h0);
      chk("t6_rst_data", rr_out_data, 32'h0);
      chk("t6_rst_src", 32'(rr_out_src), 32'h0);
      #1;
      chk("t6_first_ready", 32'(rr_in_ready), 32'h08);
      tick();
      chk("t6_first_src", 32'(rr_out_src), 32'h3);
      chk("t6_first_data", rr_out_data, 32'h3333_0003);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
